// File: rtl/mem_chk_pkg.sv
// Shared types for the memory protocol checker: FSM states, error bit indices
// and a helper that picks the lowest-numbered error raised in a cycle.
package mem_chk_pkg;

  localparam int NUM_ERR = 6;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    ERR_TIMEOUT  = 3'd0,
    ERR_UNSTABLE = 3'd1,
    ERR_DROP     = 3'd2,
    ERR_RANGE    = 3'd3,
    ERR_MISMATCH = 3'd4,
    ERR_UNINIT   = 3'd5
  } err_idx_e;

  function automatic logic [2:0] lowest_err(input logic [NUM_ERR-1:0] ev);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (ev[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_chk_shadow.sv
// Shadow copy of the checked memory: one write port landing at the clock edge,
// a combinational read port, and per-location written bits cleared by reset.
module mem_chk_shadow
  import mem_chk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IW    = 4,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvld
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = vld_q;
    if (we) vld_d[waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_d;
  end

  // Data needs no reset: it is only trusted once its written bit is set.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
  assign rvld  = vld_q[raddr];

endmodule

// File: rtl/mem_proto_checker.sv
// Passive checker for a valid/ready memory port; it never drives the interface.
// Flags and counters update one edge after the event; read data is judged RD_LATENCY cycles after its handshake.
module mem_proto_checker
  import mem_chk_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 0,
  parameter int MAX_WAIT   = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  valid,
  input  logic                  ready,
  input  logic                  clr_err,
  output logic [NUM_ERR-1:0]    err_flags,
  output logic                  err_irq,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      wr_count,
  output logic [CNT_W-1:0]      rd_count,
  output logic [2:0]            first_err_code,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PD  = (RD_LATENCY > 0) ? RD_LATENCY : 1;
  localparam int WCW = $clog2(MAX_WAIT + 1);

  state_e                state_q, state_d;
  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                  lt_wr_q, lt_wr_d, unst_q, unst_d;
  logic [ADDR_WIDTH-1:0] lt_addr_q, lt_addr_d;
  logic [WIDTH-1:0]      lt_wdata_q, lt_wdata_d;
  logic [PD-1:0]         pv_q, pv_d;
  logic [WIDTH-1:0]      pe_q [PD], pe_d [PD];
  logic [ADDR_WIDTH-1:0] pa_q [PD], pa_d [PD];
  logic [NUM_ERR-1:0]    flags_q, flags_d, flags_base;
  logic                  irq_q, irq_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d, err_cnt_base;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [CNT_W+2:0]      err_sum;
  logic [2:0]            fcode_q, fcode_d, low_idx;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;

  logic                  xfer, in_range, rd_push, sh_we, sh_vld;
  logic [WIDTH-1:0]      sh_rdata;
  logic                  chk_vld;
  logic [WIDTH-1:0]      chk_exp;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [NUM_ERR-1:0]    ev;
  logic [ADDR_WIDTH-1:0] ev_addr [NUM_ERR];

  assign xfer     = valid && ready;
  assign in_range = (int'(addr) < DEPTH);
  assign sh_we    = rst && xfer && wr_rd && in_range;
  assign rd_push  = xfer && !wr_rd && in_range && sh_vld;

  mem_chk_shadow #(.WIDTH(WIDTH), .IW(IW), .DEPTH(DEPTH)) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .we    (sh_we),
    .waddr (addr[IW-1:0]),
    .wdata (wdata),
    .raddr (addr[IW-1:0]),
    .rdata (sh_rdata),
    .rvld  (sh_vld)
  );

  // Expected data travels with its address so a late mismatch still reports where it came from.
  always_comb begin
    pv_d[0] = rd_push;
    pe_d[0] = sh_rdata;
    pa_d[0] = addr;
    for (int i = 1; i < PD; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
    chk_vld  = (RD_LATENCY == 0) ? rd_push  : pv_q[PD-1];
    chk_exp  = (RD_LATENCY == 0) ? sh_rdata : pe_q[PD-1];
    chk_addr = (RD_LATENCY == 0) ? addr     : pa_q[PD-1];
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lt_wr_d    = lt_wr_q;
    lt_addr_d  = lt_addr_q;
    lt_wdata_d = lt_wdata_q;
    unst_d     = unst_q;
    ev         = '0;
    for (int i = 0; i < NUM_ERR; i++) ev_addr[i] = lt_addr_q;
    ev_addr[ERR_RANGE]    = addr;
    ev_addr[ERR_UNINIT]   = addr;
    ev_addr[ERR_MISMATCH] = chk_addr;
    case (state_q)
      IDLE: begin
        if (valid && !ready) begin
          state_d    = WAIT;
          wait_cnt_d = WCW'(1);
          lt_wr_d    = wr_rd;
          lt_addr_d  = addr;
          lt_wdata_d = wdata;
          unst_d     = 1'b0;
          if (MAX_WAIT == 1) begin
            ev[ERR_TIMEOUT]      = 1'b1;
            ev_addr[ERR_TIMEOUT] = addr;
          end
        end
      end
      WAIT: begin
        if (!valid) begin
          ev[ERR_DROP] = 1'b1;
          state_d      = IDLE;
        end else begin
          if (!unst_q && (wr_rd != lt_wr_q || addr != lt_addr_q || wdata != lt_wdata_q)) begin
            ev[ERR_UNSTABLE] = 1'b1;
            unst_d           = 1'b1;
          end
          // The count saturates at MAX_WAIT, which keeps the timeout to one event per request.
          if (ready) begin
            state_d = IDLE;
          end else if (wait_cnt_q != WCW'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
            if (wait_cnt_d == WCW'(MAX_WAIT)) ev[ERR_TIMEOUT] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer && !in_range)                     ev[ERR_RANGE]    = 1'b1;
    if (xfer && !wr_rd && in_range && !sh_vld) ev[ERR_UNINIT]   = 1'b1;
    if (chk_vld && rdata != chk_exp)           ev[ERR_MISMATCH] = 1'b1;
  end

  // A clear and a new error in the same cycle: clear first, then the new error lands.
  always_comb begin
    flags_base   = clr_err ? '0 : flags_q;
    err_cnt_base = clr_err ? '0 : err_cnt_q;
    flags_d      = flags_base | ev;
    irq_d        = |flags_d;
    err_sum      = {3'b000, err_cnt_base} + (CNT_W+3)'($countones(ev));
    err_cnt_d    = (err_sum[CNT_W+2:CNT_W] != 3'b000) ? '1 : err_sum[CNT_W-1:0];
    fcode_d      = clr_err ? 3'd0 : fcode_q;
    faddr_d      = clr_err ? '0 : faddr_q;
    low_idx      = lowest_err(ev);
    if (flags_base == '0 && ev != '0) begin
      fcode_d = low_idx;
      faddr_d = ev_addr[low_idx];
    end
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (xfer && wr_rd && wr_cnt_q != '1)  wr_cnt_d = wr_cnt_q + CNT_W'(1);
    if (xfer && !wr_rd && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      lt_wr_q    <= 1'b0;
      lt_addr_q  <= '0;
      lt_wdata_q <= '0;
      unst_q     <= 1'b0;
      pv_q       <= '0;
      flags_q    <= '0;
      irq_q      <= 1'b0;
      err_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      fcode_q    <= '0;
      faddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lt_wr_q    <= lt_wr_d;
      lt_addr_q  <= lt_addr_d;
      lt_wdata_q <= lt_wdata_d;
      unst_q     <= unst_d;
      pv_q       <= pv_d;
      flags_q    <= flags_d;
      irq_q      <= irq_d;
      err_cnt_q  <= err_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      fcode_q    <= fcode_d;
      faddr_q    <= faddr_d;
    end
  end

  always_ff @(posedge clk) begin
    pe_q <= pe_d;
    pa_q <= pa_d;
  end

  assign err_flags      = flags_q;
  assign err_irq        = irq_q;
  assign err_count      = err_cnt_q;
  assign wr_count       = wr_cnt_q;
  assign rd_count       = rd_cnt_q;
  assign first_err_code = fcode_q;
  assign first_err_addr = faddr_q;

endmodule

// File: tb/tb_mem_proto_checker.sv
// Bench for mem_proto_checker: directed scenarios then random traffic, every cycle
// compared against a transaction-level model (pending request, shadow map, due-time read queue).
module tb_mem_proto_checker;

  localparam int W     = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int MAXW  = 8;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, wr_rd, valid, ready, clr_err;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata, rdata;
  logic [5:0]    err_flags;
  logic          err_irq;
  logic [CW-1:0] err_count, wr_count, rd_count;
  logic [2:0]    first_err_code;
  logic [AW-1:0] first_err_addr;

  always #5 clk = ~clk;

  mem_proto_checker #(
    .WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT), .MAX_WAIT(MAXW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .wr_rd(wr_rd), .addr(addr), .wdata(wdata), .rdata(rdata),
    .valid(valid), .ready(ready), .clr_err(clr_err), .err_flags(err_flags), .err_irq(err_irq),
    .err_count(err_count), .wr_count(wr_count), .rd_count(rd_count),
    .first_err_code(first_err_code), .first_err_addr(first_err_addr)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { int exp; int addr; int due; } rd_t;

  bit       m_pend, m_unst, m_pwr;
  int       m_paddr, m_pwd, m_waited, m_cyc;
  int       shadow [int];
  rd_t      rq [$];
  bit [5:0] m_flags, m_ev;
  int       m_ea [6];
  int       m_ecnt, m_wcnt, m_rcnt, m_fcode, m_faddr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic raise(int idx, int a);
    m_ev[idx] = 1'b1;
    m_ea[idx] = a;
  endtask

  task automatic model_xfer();
    int  a;
    rd_t e;
    a = int'(addr);
    if (wr_rd) m_wcnt = (m_wcnt < CMAX) ? m_wcnt + 1 : CMAX;
    else       m_rcnt = (m_rcnt < CMAX) ? m_rcnt + 1 : CMAX;
    if (a >= DEPTH) raise(3, a);
    else if (wr_rd) shadow[a] = int'(wdata);
    else if (!shadow.exists(a)) raise(5, a);
    else begin
      e.exp  = shadow[a];
      e.addr = a;
      e.due  = m_cyc + LAT;
      rq.push_back(e);
    end
  endtask

  // Applies the inputs currently driven for this cycle to the model.
  task automatic model_step();
    bit [5:0] base;
    rd_t      e;
    m_ev = '0;
    for (int i = 0; i < 6; i++) m_ea[i] = 0;
    if (!rst) begin
      m_pend = 1'b0;
      shadow.delete();
      rq.delete();
      m_flags = '0;
      m_ecnt = 0; m_wcnt = 0; m_rcnt = 0; m_fcode = 0; m_faddr = 0;
    end else begin
      if (m_pend) begin
        if (!valid) begin
          raise(2, m_paddr);
          m_pend = 1'b0;
        end else begin
          if (!m_unst && (wr_rd != m_pwr || int'(addr) != m_paddr || int'(wdata) != m_pwd)) begin
            raise(1, m_paddr);
            m_unst = 1'b1;
          end
          if (ready) begin
            model_xfer();
            m_pend = 1'b0;
          end else begin
            m_waited++;
            if (m_waited == MAXW) raise(0, m_paddr);
          end
        end
      end else if (valid) begin
        if (ready) model_xfer();
        else begin
          m_pend = 1'b1; m_pwr = wr_rd; m_paddr = int'(addr); m_pwd = int'(wdata);
          m_unst = 1'b0; m_waited = 1;
          if (m_waited == MAXW) raise(0, m_paddr);
        end
      end
      if (rq.size() > 0 && rq[0].due == m_cyc) begin
        e = rq.pop_front();
        if (int'(rdata) != e.exp) raise(4, e.addr);
      end
      base = clr_err ? 6'b0 : m_flags;
      if (clr_err) begin m_ecnt = 0; m_fcode = 0; m_faddr = 0; end
      if (base == 6'b0 && m_ev != 6'b0) begin
        for (int i = 5; i >= 0; i--) if (m_ev[i]) begin m_fcode = i; m_faddr = m_ea[i]; end
      end
      m_ecnt += $countones(m_ev);
      if (m_ecnt > CMAX) m_ecnt = CMAX;
      m_flags = base | m_ev;
    end
    m_cyc++;
  endtask

  task automatic step(bit rn, bit v, bit rdy, bit wr, int a, int wd, int rd, bit clr);
    rst = rn; valid = v; ready = rdy; wr_rd = wr;
    addr = AW'(a); wdata = W'(wd); rdata = W'(rd); clr_err = clr;
    model_step();
    @(posedge clk);
    #1;
    chk("err_flags",      32'(err_flags),      32'(m_flags));
    chk("err_irq",        32'(err_irq),        32'(m_flags != 6'b0));
    chk("err_count",      32'(err_count),      m_ecnt);
    chk("wr_count",       32'(wr_count),       m_wcnt);
    chk("rd_count",       32'(rd_count),       m_rcnt);
    chk("first_err_code", 32'(first_err_code), m_fcode);
    chk("first_err_addr", 32'(first_err_addr), m_faddr);
  endtask

  task automatic idle(int rd, bit clr);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, rd, clr);
  endtask

  initial begin
    bit hwr;
    int ha, hwd;
    hwr = 1'b0; ha = 0; hwd = 0;
    m_cyc = 0; m_pend = 1'b0; m_flags = '0;
    m_ecnt = 0; m_wcnt = 0; m_rcnt = 0; m_fcode = 0; m_faddr = 0;

    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3, 'h99, 0, 1'b0);
    chk("reset_flags", 32'(err_flags), 0);
    chk("reset_wr_count", 32'(wr_count), 0);

    // Basic write then read-back with matching data.
    step(1'b1, 1'b1, 1'b1, 1'b1, 3, 'hA5, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3, 0, 'hA5, 1'b0);
    idle('hA5, 1'b0);
    idle('hA5, 1'b0);
    chk("t1_wr_count", 32'(wr_count), 1);
    chk("t1_rd_count", 32'(rd_count), 1);
    chk("t1_flags", 32'(err_flags), 0);

    // Ready withheld for MAX_WAIT cycles.
    for (int i = 0; i < MAXW; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1, 'h11, 0, 1'b0);
      if (i == MAXW - 2) chk("t2_no_early_timeout", 32'(err_flags), 0);
    end
    chk("t2_timeout_flag", 32'(err_flags), 32'h01);
    chk("t2_err_count", 32'(err_count), 1);
    chk("t2_irq", 32'(err_irq), 1);
    chk("t2_first_addr", 32'(first_err_addr), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1, 'h11, 0, 1'b0);
    idle(0, 1'b0);
    chk("t2_after_ready_count", 32'(err_count), 1);
    chk("t2_wr_count", 32'(wr_count), 2);

    // Address changes mid-wait, then valid drops.
    idle(0, 1'b1);
    chk("t3_cleared", 32'(err_flags), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5, 0, 0, 1'b0);
    chk("t3_unstable", 32'(err_flags), 32'h02);
    chk("t3_first_addr", 32'(first_err_addr), 2);
    idle(0, 1'b0);
    chk("t3_drop", 32'(err_flags), 32'h06);
    chk("t3_err_count", 32'(err_count), 2);

    // Delayed read data mismatch, then a read of a never-written location.
    idle(0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 7, 'h3C, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 7, 0, 0, 1'b0);
    idle(0, 1'b0);
    idle('h3D, 1'b0);
    chk("t4_mismatch", 32'(err_flags), 32'h10);
    chk("t4_first_code", 32'(first_err_code), 4);
    chk("t4_first_addr", 32'(first_err_addr), 7);
    step(1'b1, 1'b1, 1'b1, 1'b0, 9, 0, 0, 1'b0);
    chk("t4_uninit", 32'(err_flags), 32'h30);

    // Out-of-range write must not alias into the shadow; clear collides with a new error.
    idle(0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 20, 'h77, 0, 1'b0);
    chk("t5_range", 32'(err_flags), 32'h08);
    chk("t5_first_addr", 32'(first_err_addr), 20);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4, 0, 0, 1'b0);
    chk("t5_no_alias", 32'(err_flags), 32'h28);
    step(1'b1, 1'b1, 1'b1, 1'b0, 7, 0, 0, 1'b0);
    idle(0, 1'b0);
    idle('h00, 1'b1);
    chk("t5_clr_vs_new", 32'(err_flags), 32'h10);
    chk("t5_clr_count", 32'(err_count), 1);

    // Reset while waiting with reads in flight.
    step(1'b1, 1'b1, 1'b1, 1'b0, 7, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1, 'h55, 'h3C, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1, 'h55, 'hEE, 1'b0);
    chk("t6_flags", 32'(err_flags), 0);
    chk("t6_err_count", 32'(err_count), 0);
    chk("t6_rd_count", 32'(rd_count), 0);
    idle('hEE, 1'b0);
    idle('hEE, 1'b0);
    chk("t6_no_stale_mismatch", 32'(err_flags), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 7, 0, 0, 1'b0);
    chk("t6_uninit", 32'(err_flags), 32'h20);
    chk("t6_uninit_addr", 32'(first_err_addr), 7);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      bit v, rdy, clr, rn;
      int rd;
      if (!m_pend || $urandom_range(11) == 0) begin
        hwr = ($urandom_range(1) == 1);
        ha  = int'($urandom_range(DEPTH + 3));
        hwd = int'($urandom_range(255));
      end
      v   = m_pend ? ($urandom_range(15) != 0) : ($urandom_range(2) != 0);
      rdy = (n < 400) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
      if (rq.size() > 0 && rq[0].due == m_cyc)
        rd = ($urandom_range(9) == 0) ? (rq[0].exp ^ 1) : rq[0].exp;
      else
        rd = int'($urandom_range(255));
      clr = ($urandom_range(31) == 0);
      rn  = ($urandom_range(199) != 0);
      step(rn, v, rdy, hwr, ha, hwd, rd, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
